// File: rtl/product_bcd_display.sv
// Captures an 8-bit product, converts it to three BCD digits with a sequential
// shift-add-3 engine, and scans the result onto a 3-digit active-high 7-segment display.
module product_bcd_display #(
  parameter int REFRESH_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] product,
  input  logic       load,
  output logic       busy,
  output logic       bcd_valid,
  output logic [11:0] bcd,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [11:0]   scratch_q, scratch_d;
  logic [2:0]    iter_q, iter_d;
  logic [11:0]   bcd_q, bcd_d;
  logic          bcd_valid_q, bcd_valid_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0]    digit_q, digit_d;
  logic [11:0]   adj;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [11:0] add3_nibbles(input logic [11:0] v);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (v[i*4 +: 4] >= 4'd5) ? v[i*4 +: 4] + 4'd3 : v[i*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    scratch_d   = scratch_q;
    iter_d      = iter_q;
    bcd_d       = bcd_q;
    bcd_valid_d = bcd_valid_q;
    adj         = add3_nibbles(scratch_q);
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d   = CONVERT;
          shift_d   = product;
          scratch_d = 12'h000;
          iter_d    = 3'd0;
        end
      end
      CONVERT: begin
        {scratch_d, shift_d} = {adj, shift_q} << 1;
        iter_d = iter_q + 3'd1;
        // The eighth shift leaves the finished digits in scratch_d.
        if (iter_q == 3'd7) begin
          state_d     = IDLE;
          bcd_d       = scratch_d;
          bcd_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    refresh_d = refresh_q + RW'(1);
    digit_d   = digit_q;
    if (refresh_q == REFRESH_MAX) begin
      refresh_d = '0;
      digit_d   = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      iter_q      <= 3'd0;
      bcd_q       <= 12'h000;
      bcd_valid_q <= 1'b0;
      refresh_q   <= '0;
      digit_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      refresh_q   <= refresh_d;
      digit_q     <= digit_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q   <= shift_d;
    scratch_q <= scratch_d;
  end

  // Leading-zero blanking keeps the digit enable but drives no segments.
  always_comb begin
    nib   = bcd_q[3:0];
    blank = 1'b0;
    an    = 3'b000;
    seg   = 7'h00;
    case (digit_q)
      2'd1: begin
        nib   = bcd_q[7:4];
        blank = (bcd_q[11:4] == 8'h00);
      end
      2'd2: begin
        nib   = bcd_q[11:8];
        blank = (bcd_q[11:8] == 4'h0);
      end
      default: ;
    endcase
    if (bcd_valid_q) begin
      an  = 3'b001 << digit_q;
      seg = blank ? 7'h00 : seg_decode(nib);
    end
  end

  assign busy      = (state_q == CONVERT);
  assign bcd_valid = bcd_valid_q;
  assign bcd       = bcd_q;

endmodule

// File: tb/tb_product_bcd_display.sv
// Randomised/directed bench for product_bcd_display with a queue scoreboard and
// an arithmetic reference model of conversion timing, blanking and digit scan.
module tb_product_bcd_display;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  product = 8'h00;
  logic        load = 1'b0;
  logic        busy, bcd_valid;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [2:0]  an;

  product_bcd_display #(.REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .product(product), .load(load),
    .busy(busy), .bcd_valid(bcd_valid), .bcd(bcd), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  // Reference model state
  int          cyc = 0;
  int          last_acc = -1000;
  int          next_free = 0;
  int          since = 0;
  logic [11:0] pend = 12'h000;
  logic [11:0] bcd_m = 12'h000;
  logic        valid_m = 1'b0;
  logic        prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic logic [6:0] segof(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic tick();
    int dig, h, t, o;
    logic [2:0] an_e;
    logic [6:0] seg_e;
    logic busy_e;
    @(posedge clk);
    cyc++;
    if (rst) begin
      valid_m = 1'b0; bcd_m = 12'h000; since = 0;
      last_acc = -1000; next_free = 0;
      exp_q.delete();
    end else begin
      since++;
      if (cyc == last_acc + 8) begin
        bcd_m = pend; valid_m = 1'b1;
      end
      if (load && cyc >= next_free) begin
        last_acc = cyc; next_free = cyc + 9;
        pend = to_bcd(int'(product));
        exp_q.push_back(pend);
      end
    end
    #1;
    busy_e = (cyc >= last_acc) && (cyc <= last_acc + 7);
    dig = (since / RD) % 3;
    h = int'(bcd_m[11:8]); t = int'(bcd_m[7:4]); o = int'(bcd_m[3:0]);
    an_e = 3'b000; seg_e = 7'h00;
    if (valid_m) begin
      an_e = 3'b001 << dig;
      if (dig == 0) seg_e = segof(o);
      else if (dig == 1) seg_e = (h == 0 && t == 0) ? 7'h00 : segof(t);
      else seg_e = (h == 0) ? 7'h00 : segof(h);
    end
    chk("busy", busy, busy_e);
    chk("bcd_valid", bcd_valid, valid_m);
    chk("bcd", bcd, bcd_m);
    chk("an", an, an_e);
    chk("seg", seg, seg_e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input int v);
    load = 1'b1;
    product = 8'(v);
    tick();
    load = 1'b0;
    product = 8'($urandom_range(0, 255));
  endtask

  // Monitor: a conversion result is presented when busy falls outside reset.
  always @(negedge clk) begin
    logic [11:0] e;
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_result", 32'(bcd), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_bcd", bcd, e);
          chk("sb_valid", bcd_valid, 1'b1);
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    ticks(2);
    chk("rst_bcd", bcd, 12'h000);
    chk("rst_an", an, 3'b000);
    chk("rst_seg", seg, 7'h00);
    rst = 1'b0;
    ticks(20);

    do_load(225);
    ticks(7);
    chk("busy_c8", busy, 1'b1);
    tick();
    chk("bcd_225", bcd, 12'h225);
    chk("busy_c9", busy, 1'b0);
    ticks(3 * RD * 2);

    do_load(7);   ticks(8 + 3 * RD);
    chk("bcd_7", bcd, 12'h007);
    do_load(0);   ticks(8 + 3 * RD);
    chk("bcd_0", bcd, 12'h000);
    do_load(105); ticks(8 + 3 * RD);
    chk("bcd_105", bcd, 12'h105);

    // Overlap: loads in cycles 3 and 8 ignored, cycle 9 accepted.
    do_load(42);
    ticks(2);
    do_load(99);
    ticks(4);
    do_load(99);
    chk("bcd_42", bcd, 12'h042);
    do_load(99);
    chk("busy_reaccept", busy, 1'b1);
    ticks(8);
    chk("bcd_99", bcd, 12'h099);

    // Reset in the middle of a conversion.
    do_load(81); ticks(8);
    chk("bcd_81", bcd, 12'h081);
    do_load(200); ticks(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_bcd", bcd, 12'h000);
    chk("midrst_valid", bcd_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    ticks(5);
    do_load(200); ticks(8);
    chk("bcd_200", bcd, 12'h200);

    for (int v = 0; v < 256; v++) begin
      do_load(v);
      ticks(8);
    end
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_load(a * b);
        ticks(8 + int'($urandom_range(0, 2)));
      end
    end
    for (int i = 0; i < 40; i++) begin
      load = ($urandom_range(0, 3) == 0);
      product = 8'($urandom_range(0, 255));
      tick();
    end
    load = 1'b0;
    ticks(12);
    chk("sb_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/product_bcd_display.md
# product_bcd_display

Downstream consumer of the 4-bit multiplier's 8-bit `Product`. The block captures a product on a load strobe and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine. It then drives a time-multiplexed, active-high 7-segment display with leading-zero blanking. It accepts any 8-bit value (0–255), not only the multiplier's 0–225 range.

## Interface
- `REFRESH_DIV`, 1024: clock cycles each digit stays enabled before the scan advances. Must be ≥ 2.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `product`  in  8  unsigned value to convert; sampled only when `load` is accepted.
- `load`  in  1  start request; accepted only in IDLE.
- `busy`  out  1  high while a conversion is in progress.
- `bcd_valid`  out  1  high once at least one conversion has completed since reset.
- `bcd`  out  12  last converted result, {hundreds, tens, ones}, 4 bits each.
- `seg`  out  7  {g,f,e,d,c,b,a}, active-high segments for the enabled digit.
- `an`  out  3  one-hot digit enable, active-high; an[0]=ones, an[1]=tens, an[2]=hundreds.

## Operation
- FSM states: IDLE and CONVERT.
- IDLE → CONVERT: when `load`=1.
  - Copy `product` into an 8-bit shift register.
  - Clear the 12-bit scratch BCD register.
  - Clear the iteration counter.
- CONVERT, each cycle:
  - Add 3 to every scratch nibble that is ≥ 5.
  - Then shift {scratch, shift register} left by 1.
  - Increment the iteration counter.
- CONVERT → IDLE: after the 8th iteration.
  - The final shifted scratch value is written into `bcd`.
  - `bcd_valid` is set.
- `load` while in CONVERT is ignored. There is no queueing and no error flag.
- `bcd` changes only at conversion completion. The display keeps showing the previous result while a conversion runs.
- Scan:
  - The refresh counter runs 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On wrap, the digit index advances ones → tens → hundreds → ones.
- Digit decode (combinational from registered state):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Nibble >9 → 0x00 (unreachable; listed for completeness).
- Blanking:
  - Hundreds is blank if 0.
  - Tens is blank if both hundreds and tens are 0.
  - Ones is never blank.
  - For a blank digit, `an` stays at its one-hot value and `seg`=0x00.
- While `bcd_valid`=0: `seg`=0x00 and `an`=3'b000.

## Timing
- Reset, applied at any rising edge with `rst`=1, including mid-conversion:
  - FSM returns to IDLE; an in-flight conversion is discarded.
  - `busy`=0, `bcd_valid`=0, `bcd`=12'h000.
  - Refresh counter = 0, digit index = ones.
  - `seg`=0x00, `an`=3'b000.
  - `rst` has priority over `load` in the same cycle.
- Conversion latency (cycle 0 = the cycle `load` is sampled high in IDLE):
  - `busy`=1 in cycles 1–8.
  - New `bcd` and `bcd_valid`=1 are visible in cycle 9, with `busy`=0.
  - A `load` in cycle 8 is ignored; a `load` in cycle 9 is accepted.
  - Maximum throughput: one conversion per 9 cycles.
- Scan timing: each digit is enabled for exactly REFRESH_DIV cycles. The full three-digit frame is 3·REFRESH_DIV cycles.
- `seg` and `an` update in the same cycle as the digit index or `bcd` changes.

## Test plan
Bench uses REFRESH_DIV=4.
- Reset: hold `rst` 2 cycles → `busy`=0, `bcd_valid`=0, `bcd`=0x000, `an`=000, `seg`=0x00. Release, then wait 20 cycles → outputs unchanged.
- Load 225 (15×15) → `busy`=1 for exactly cycles 1–8. Cycle 9: `bcd`=0x225, `bcd_valid`=1. Scan then shows an=001/seg=0x6D, an=010/seg=0x5B, an=100/seg=0x5B, 4 cycles each, repeating.
- Load 7 → `bcd`=0x007. Ones shows 0x07; tens and hundreds show seg=0x00 while their `an` bit is high. Load 0 → ones shows 0x3F, others blank. Load 105 → tens shows 0x3F (not blanked).
- Overlap: load 42, then assert `load` with 99 in cycles 3 and 8 → result is 0x042. Load 99 in cycle 9 → accepted, and 0x099 appears 9 cycles later.
- Reset at cycle 5 of a conversion of 200, with a prior result of 0x081 → `bcd`=0x000, `bcd_valid`=0, `busy`=0. A fresh load of 200 then yields 0x200.
- Sweep `product` 0..255, one load per 9 cycles → `bcd` equals the decimal digits of each value. Compare against the multiplier output for all 16×16 A/B pairs.
